// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// fetch-buffer entry layout and default configuration constants.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DRAIN,
        HALT
    } fetch_state_t;

    localparam int unsigned DEFAULT_ADDR_W       = 64;
    localparam int unsigned DEFAULT_DATA_W       = 32;
    localparam int unsigned DEFAULT_STEP         = 4;
    localparam logic [63:0] DEFAULT_RESET_VECTOR = '0;

    // Entry layout at the default widths; the top builds the same shape at its own widths.
    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] pc;
        logic [DEFAULT_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched {pc, instr} entries.
// Flush empties the buffer and overrides any push or pop in the same cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter type         T     = fetch_entry_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  T                         wdata,
    output T                         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, single-outstanding instruction fetch, buffered
// delivery to decode over valid/ready, with redirect/flush and halt.
// Optional macro FETCH_MISALIGN_CHECK_EN: align redirect targets to STEP and
// raise a sticky misaligned flag for unaligned targets.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned          ADDR_W       = DEFAULT_ADDR_W,
    parameter int unsigned          DATA_W       = DEFAULT_DATA_W,
    parameter int unsigned          STEP         = DEFAULT_STEP,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter int unsigned          DEPTH        = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                halt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [DATA_W-1:0]   out_instr,
    output logic                halted,
    output logic                misaligned
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_nxt;
    logic [ADDR_W-1:0]  req_addr;
    logic               halt_pend;
    logic               halt_pend_nxt;
    logic               req_c;
    logic               issue;
    logic               push;
    logic               flush;
    logic               pop;
    logic [ADDR_W-1:0]  redirect_target;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               can_issue;
    entry_t             push_entry;
    entry_t             head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(STEP - 1);

    assign redirect_target = redirect_pc & ~STEP_MASK;

    // Sticky flag for any redirect whose target is not a multiple of STEP.
    always_ff @(posedge clk) begin
        if (reset)
            misaligned <= 1'b0;
        else if (redirect_valid && ((redirect_pc & STEP_MASK) != '0))
            misaligned <= 1'b1;
    end
`else
    assign redirect_target = redirect_pc;
    assign misaligned      = 1'b0;
`endif

    // The outstanding request is always retired before a new one is issued,
    // so checking occupancy at issue time guarantees room for the push.
    assign can_issue = (fifo_count < CW'(DEPTH));

    // The address is held in req_addr once issued because a redirect
    // overwrites pc while the old request is still draining.
    assign mem_addr  = (state == FETCH) ? pc : req_addr;
    assign mem_req   = req_c && !reset;
    assign issue     = (state == FETCH) && req_c;
    assign halted    = (state == HALT);

    assign pop        = out_valid && out_ready;
    assign push_entry = '{pc: mem_addr, instr: mem_rdata};
    assign out_valid  = !fifo_empty;
    assign out_pc     = head_entry.pc;
    assign out_instr  = head_entry.instr;

    // State, PC, pending-halt and in-flight address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_VECTOR;
            halt_pend <= 1'b0;
            req_addr  <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            halt_pend <= halt_pend_nxt;
            if (issue) req_addr <= pc;
        end
    end

    // Next-state, request and buffer-control decode; redirect dominates.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        halt_pend_nxt = halt_pend;
        req_c         = 1'b0;
        push          = 1'b0;
        flush         = 1'b0;
        unique case (state)
            FETCH: begin
                if (redirect_valid) begin
                    flush  = 1'b1;
                    pc_nxt = redirect_target;
                end else if (halt) begin
                    state_nxt = HALT;
                end else if (can_issue) begin
                    req_c = 1'b1;
                    if (mem_ack) begin
                        push   = 1'b1;
                        pc_nxt = pc + ADDR_W'(STEP);
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                req_c = 1'b1;
                if (redirect_valid) begin
                    flush         = 1'b1;
                    pc_nxt        = redirect_target;
                    halt_pend_nxt = 1'b0;
                    state_nxt     = mem_ack ? FETCH : DRAIN;
                end else if (mem_ack) begin
                    push          = 1'b1;
                    pc_nxt        = pc + ADDR_W'(STEP);
                    halt_pend_nxt = 1'b0;
                    state_nxt     = (halt_pend || halt) ? HALT : FETCH;
                end else if (halt) begin
                    halt_pend_nxt = 1'b1;
                end
            end
            DRAIN: begin
                req_c = 1'b1;
                if (redirect_valid) begin
                    flush         = 1'b1;
                    pc_nxt        = redirect_target;
                    halt_pend_nxt = 1'b0;
                    if (mem_ack) state_nxt = FETCH;
                end else if (mem_ack) begin
                    halt_pend_nxt = 1'b0;
                    state_nxt     = (halt_pend || halt) ? HALT : FETCH;
                end else if (halt) begin
                    halt_pend_nxt = 1'b1;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    flush     = 1'b1;
                    pc_nxt    = redirect_target;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    fetch_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (push_entry),
        .rdata (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int unsigned AW    = 64;
    localparam int unsigned DW    = 32;
    localparam int unsigned STEP  = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          halt;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [DW-1:0] out_instr;
    logic          halted;
    logic          misaligned;

    // Narrow-address instance exercising PC wrap with zero-latency memory.
    logic          req8, ack8, ov8, halted8, mis8;
    logic [7:0]    addr8, opc8;
    logic [31:0]   rdata8, oinstr8;

    assign ack8   = req8;
    assign rdata8 = {24'h0, addr8};

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STEP         (STEP),
        .RESET_VECTOR (64'h0),
        .DEPTH        (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .halted         (halted),
        .misaligned     (misaligned)
    );

    fetch_unit #(
        .ADDR_W       (8),
        .DATA_W       (32),
        .STEP         (4),
        .RESET_VECTOR (8'hFC),
        .DEPTH        (4)
    ) dut8 (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (req8),
        .mem_addr       (addr8),
        .mem_ack        (ack8),
        .mem_rdata      (rdata8),
        .redirect_valid (1'b0),
        .redirect_pc    (8'h00),
        .halt           (1'b0),
        .out_valid      (ov8),
        .out_ready      (1'b1),
        .out_pc         (opc8),
        .out_instr      (oinstr8),
        .halted         (halted8),
        .misaligned     (mis8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: answers each request after lat_mode cycles (random 0..2 when negative).
    int lat_mode = 1;
    int lat      = 0;
    bit busy     = 1'b0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #3;
            if (reset || !mem_req) begin
                mem_ack = 1'b0;
                busy    = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    lat  = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
                end
                if (lat == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 32'(mem_addr >> 2);
                    busy      = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                    lat--;
                end
            end
        end
    end

    // Reference model: delivered words form a +STEP stream restarted at each
    // redirect target; a request outstanding at a redirect yields no word.
    logic [63:0] exp_pc, fetch_pc, held_addr, tgt;
    int          occ;
    bit          stale, inflight;
    int          acks, pops;
    logic [63:0] popped[$];
    logic [31:0] popped_instr[$];
    logic [7:0]  popped8[$];

    always @(negedge clk) begin
        if (reset) begin
            exp_pc   = 64'h0;
            fetch_pc = 64'h0;
            occ      = 0;
            stale    = 1'b0;
            inflight = 1'b0;
            acks     = 0;
            pops     = 0;
        end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
            tgt = redirect_pc & ~64'(STEP - 1);
`else
            tgt = redirect_pc;
            chk("misaligned_tied", 64'(misaligned), 64'h0);
`endif
            chk("out_valid", 64'(out_valid), 64'(occ != 0));
            if (halted) chk("halted_no_req", 64'(mem_req), 64'h0);
            if (inflight) begin
                chk("req_held", 64'(mem_req), 64'h1);
                chk("addr_stable", mem_addr, held_addr);
            end else if (mem_req) begin
                chk("issue_room", 64'(occ < int'(DEPTH)), 64'h1);
                chk("issue_while_halt", 64'(halt), 64'h0);
                held_addr = mem_addr;
            end
            if (out_valid && out_ready && !redirect_valid) begin
                chk("out_pc", out_pc, exp_pc);
                chk("out_instr", 64'(out_instr), 64'(32'(exp_pc >> 2)));
                popped.push_back(out_pc);
                popped_instr.push_back(out_instr);
                exp_pc = exp_pc + 64'(STEP);
                occ--;
                pops++;
            end
            if (mem_req && mem_ack) begin
                if (!redirect_valid && !stale) begin
                    chk("fetch_addr", mem_addr, fetch_pc);
                    fetch_pc = fetch_pc + 64'(STEP);
                    occ++;
                    acks++;
                    chk("occupancy", 64'(occ <= int'(DEPTH)), 64'h1);
                end
                stale    = 1'b0;
                inflight = 1'b0;
            end else if (mem_req) begin
                inflight = 1'b1;
            end
            if (redirect_valid) begin
                occ      = 0;
                exp_pc   = tgt;
                fetch_pc = tgt;
                if (mem_req && !mem_ack) stale = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && ov8) begin
            chk("dut8_instr", 64'(oinstr8), 64'({24'h0, opc8}));
            popped8.push_back(opc8);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        step();
        step();
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_halted", 64'(halted), 64'h0);
        chk("rst_misaligned", 64'(misaligned), 64'h0);
        chk("rst8_halted", 64'(halted8), 64'h0);
        chk("rst8_misaligned", 64'(mis8), 64'h0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        bit found;
        bit seen8;
        int n0;
        int reqs;

        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;

        // Sequential fetch with 1-cycle memory, plus the wrapping 8-bit instance.
        lat_mode = 1;
        do_reset();
        popped.delete();
        popped_instr.delete();
        popped8.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && popped.size() < 4; i++) step();
        chk("t1_words", 64'(popped.size() >= 4), 64'h1);
        if (popped.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_pc", popped[i], 64'(i * 4));
                chk("t1_instr", 64'(popped_instr[i]), 64'(i));
            end
        end
        chk("t8_words", 64'(popped8.size() >= 4), 64'h1);
        if (popped8.size() >= 4) begin
            chk("t8_pc0", 64'(popped8[0]), 64'hFC);
            chk("t8_pc1", 64'(popped8[1]), 64'h00);
            chk("t8_pc2", 64'(popped8[2]), 64'h04);
            chk("t8_pc3", 64'(popped8[3]), 64'h08);
        end

        // Back-pressure: buffer fills to DEPTH and requests stop.
        lat_mode = 1;
        do_reset();
        for (int i = 0; i < 20; i++) step();
        #1;
        chk("t2_acks", 64'(acks), 64'd4);
        chk("t2_req_idle", 64'(mem_req), 64'h0);
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            #1;
            if (mem_req) found = 1'b1;
        end
        chk("t2_resume", 64'(found), 64'h1);
        chk("t2_resume_addr", mem_addr, 64'h10);

        // Redirect while a request to 0x8 is outstanding.
        lat_mode = 3;
        do_reset();
        out_ready = 1'b1;
        popped.delete();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            #1;
            if (mem_req && mem_addr == 64'h8) found = 1'b1;
        end
        chk("t3_req8", 64'(found), 64'h1);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        step();
        redirect_valid = 1'b0;
        n0 = popped.size();
        for (int i = 0; i < 40 && popped.size() <= n0; i++) step();
        chk("t3_words", 64'(popped.size() > n0), 64'h1);
        if (popped.size() > n0) chk("t3_first_after", popped[n0], 64'h100);
        seen8 = 1'b0;
        foreach (popped[i]) if (popped[i] == 64'h8) seen8 = 1'b1;
        chk("t3_no_pc8", 64'(seen8), 64'h0);

        // Halt pulse during WAIT, then release by redirect.
        lat_mode = 3;
        do_reset();
        out_ready = 1'b1;
        #1;
        chk("t4_first_req", 64'(mem_req), 64'h1);
        chk("t4_first_addr", mem_addr, 64'h0);
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            #1;
            if (halted) found = 1'b1;
        end
        chk("t4_halted", 64'(found), 64'h1);
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            if (mem_req) reqs++;
        end
        chk("t4_no_req", 64'(reqs), 64'h0);
        chk("t4_acks", 64'(acks), 64'h1);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t4_unhalted", 64'(halted), 64'h0);
        chk("t4_req", 64'(mem_req), 64'h1);
        chk("t4_addr", mem_addr, 64'h40);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Unaligned redirect target.
        lat_mode = 1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h102;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t6_flag", 64'(misaligned), 64'h1);
        chk("t6_req", 64'(mem_req), 64'h1);
        chk("t6_addr", mem_addr, 64'h100);
        for (int i = 0; i < 5; i++) step();
        chk("t6_sticky", 64'(misaligned), 64'h1);
`endif

        // Randomized traffic against the stream model.
        lat_mode = -1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step();
            out_ready      = ($urandom % 10) < 7;
            redirect_valid = ($urandom % 100) < 3;
            redirect_pc    = {$urandom, $urandom} & ~64'h3;
            halt           = ($urandom % 100) < 2;
        end
        step();
        redirect_valid = 1'b0;
        halt           = 1'b0;
        chk("rand_progress", 64'(pops > 100), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage: the next generation of the PC register and +4 adder loop.
- Holds the PC, issues single-outstanding read requests to instruction memory, and buffers returned words with their PC in a small FIFO.
- Delivers words to decode over a valid/ready handshake.
- Adds configurable step, reset vector, redirect (branch/jump) with flush, and halt.

Parameters:
- ADDR_W, 64, PC/address width in bits
- DATA_W, 32, instruction word width
- STEP, 4, PC increment per fetched word
- RESET_VECTOR, 0, PC value after reset
- DEPTH, 4, fetch-buffer entries (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- mem_req  out  1  read request, held until mem_ack
- mem_addr  out  ADDR_W  request address, stable while mem_req=1
- mem_ack  in  1  request completes in the cycle mem_req&mem_ack
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- redirect_valid  in  1  load new PC, flush buffer
- redirect_pc  in  ADDR_W  redirect target
- halt  in  1  stop issuing new fetches
- out_valid  out  1  buffer head valid
- out_ready  in  1  decode accepts head
- out_pc  out  ADDR_W  PC of head word
- out_instr  out  DATA_W  head word
- halted  out  1  in HALT state
- misaligned  out  1  sticky misalignment flag (optional feature only)

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk: pc=RESET_VECTOR, state=FETCH, FIFO empty. All outputs 0: mem_req, out_valid, halted, misaligned.
- States: FETCH, WAIT, DRAIN, HALT.
- FETCH: if count+0 < DEPTH and not halt, assert mem_req with mem_addr=pc, then go to WAIT; ack may be sampled the same cycle.
- WAIT: mem_req held, mem_addr=pc.
- On mem_ack:
  - push {pc, mem_rdata} into the FIFO.
  - pc <= pc+STEP, mod 2^ADDR_W; wrap silently.
  - Go to FETCH, or to HALT if halt was seen while in flight.
- Issue condition counts the outstanding request, so a push never hits a full FIFO. Full FIFO means mem_req stays low.
- Throughput: back-to-back acks give at most 1 word per 2 cycles in FETCH→WAIT. A same-cycle ack in FETCH gives 1 word per cycle.
- redirect_valid (highest priority below reset):
  - FIFO flushed; out_valid=0 next cycle.
  - pc <= redirect_pc.
  - In WAIT: go to DRAIN. mem_req stays high at the old address until ack, the data is discarded, then go to FETCH at the new pc.
  - In DRAIN: the latest redirect_pc wins.
  - In HALT: go to FETCH.
- Redirect and pop in the same cycle: flush wins and the pop is ignored.
- Redirect on the same cycle as mem_ack in WAIT: the acked data is discarded, then go directly to FETCH.
- halt:
  - Level-sampled. In FETCH it blocks issue and moves to HALT.
  - In WAIT/DRAIN the in-flight request completes first.
  - HALT asserts halted=1; the FIFO continues to drain to decode.
  - Only redirect_valid exits HALT.
- Output port:
  - FIFO head is presented combinationally from registered storage.
  - Pop occurs on out_valid&out_ready.
  - Push and pop in the same cycle keep the count unchanged.
  - Empty FIFO gives out_valid=0; out_pc/out_instr are don't-care.
- Reset mid-request: mem_req drops the next cycle. Memory must tolerate the abandoned request.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect_pc not a multiple of STEP sets sticky misaligned=1 (cleared only by reset).
  - pc <= redirect_pc with the low log2(STEP) bits cleared.
- Undefined:
  - misaligned is tied to 0.
  - redirect_pc is used unmodified.

Decomposition:
- Shared package:
  - fetch-state enum (FETCH, WAIT, DRAIN, HALT).
  - Fetch-entry struct {pc, instr}.
  - Default STEP and RESET_VECTOR constants.
- Sub-module fetch_fifo: parametrised synchronous FIFO with push, pop, flush, count and full/empty. Flush overrides push and pop.

Test Plan:
- Reset then out_ready=1; memory acks 1 cycle after req with rdata=addr>>2 -> out_pc sequence 0,4,8,12, out_instr 0,1,2,3.
- out_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 acks, then mem_req=0. Raising out_ready resumes fetching at pc=16.
- Redirect to 0x100 while in WAIT at 0x8 -> the 0x8 data is discarded, no entry with out_pc=0x8 is seen, and the next out_pc is 0x100.
- Pulse halt during WAIT -> the request completes, halted=1, no further mem_req. Redirect 0x40 -> halted=0 and mem_addr=0x40.
- ADDR_W=8, RESET_VECTOR=0xFC -> fetches 0xFC then wraps to 0x00.
- With FETCH_MISALIGN_CHECK_EN, redirect 0x102 -> misaligned=1 and mem_addr=0x100. The flag is cleared only by reset.
